// File: rtl/ascii_glyph_streamer.sv
// Glyph ROM reader: accepts ASCII characters, fetches the 8x8 glyph and streams it
// as 8 column bytes, tracking line position and expanding LF into blank padding.
module ascii_glyph_streamer #(
    parameter int CHARS_PER_LINE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    input  logic        char_inv,
    output logic        char_ready,
    output logic [7:0]  rom_addr,
    input  logic [63:0] rom_data,
    output logic [7:0]  col_data,
    output logic        col_valid,
    input  logic        col_ready,
    output logic        col_last,
    output logic        line_last,
    output logic        busy
);

    localparam int POS_W = $clog2(CHARS_PER_LINE);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(CHARS_PER_LINE - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    state_t             state_q, state_d;
    logic [7:0]         rom_addr_q, rom_addr_d;
    logic [63:0]        shreg_q, shreg_d;
    logic [2:0]         col_idx_q, col_idx_d;
    logic [POS_W-1:0]   char_pos_q, char_pos_d;
    logic               pad_q, pad_d;
    logic               inv_q, inv_d;

    logic at_eol, pad_more, glyph_done, accept;

    // LF padding keeps emitting blank glyphs until the glyph at the last line position.
    assign at_eol     = (char_pos_q == LAST_POS);
    assign pad_more   = pad_q & ~at_eol;
    assign glyph_done = (state_q == S_SEND) & (col_idx_q == 3'd7) & col_ready;
    assign char_ready = (state_q == S_IDLE) | (glyph_done & ~pad_more);
    assign accept     = char_valid & char_ready;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        shreg_d    = shreg_q;
        col_idx_d  = col_idx_q;
        char_pos_d = char_pos_q;
        pad_d      = pad_q;
        inv_d      = inv_q;
        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                shreg_d   = (pad_q ? 64'h0 : rom_data) ^ {64{inv_q}};
                col_idx_d = 3'd0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (col_ready) begin
                    shreg_d   = {shreg_q[55:0], 8'h00};
                    col_idx_d = col_idx_q + 3'd1;
                    if (col_idx_q == 3'd7) begin
                        char_pos_d = at_eol ? '0 : char_pos_q + POS_W'(1);
                        if (pad_more) begin
                            state_d = S_LOAD;
                        end else begin
                            pad_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new character may be taken in the same cycle the previous glyph finishes.
        if (accept) begin
            inv_d   = char_inv;
            state_d = S_LOAD;
            if (char_in == 8'h0A)
                pad_d = 1'b1;
            else
                rom_addr_d = (char_in > 8'h7F) ? 8'h7F : {1'b0, char_in[6:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= 8'h00;
            shreg_q    <= 64'h0;
            col_idx_q  <= 3'd0;
            char_pos_q <= '0;
            pad_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            shreg_q    <= shreg_d;
            col_idx_q  <= col_idx_d;
            char_pos_q <= char_pos_d;
            pad_q      <= pad_d;
            inv_q      <= inv_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign col_valid = (state_q == S_SEND);
    assign col_data  = shreg_q[63:56];
    assign col_last  = col_valid & (col_idx_q == 3'd7);
    assign line_last = col_last & at_eol;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ascii_glyph_streamer.sv
// Bench for ascii_glyph_streamer: table vectors plus hand sequences, scoreboarded columns.
module tb_ascii_glyph_streamer;

    localparam int CPL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_inv = 1'b0;
    logic        char_ready;
    logic [7:0]  rom_addr;
    logic [63:0] rom_data;
    logic [7:0]  col_data;
    logic        col_valid;
    logic        col_ready = 1'b1;
    logic        col_last;
    logic        line_last;
    logic        busy;

    ascii_glyph_streamer #(.CHARS_PER_LINE(CPL)) dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .char_inv(char_inv), .char_ready(char_ready), .rom_addr(rom_addr),
        .rom_data(rom_data), .col_data(col_data), .col_valid(col_valid),
        .col_ready(col_ready), .col_last(col_last), .line_last(line_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rom_glyph(input logic [7:0] a);
        case (a)
            8'h41:   return 64'h407C4A094A7C4000;
            8'h42:   return 64'h417F494949493600;
            8'h43:   return 64'h3E41414122000000;
            8'h30:   return 64'h3E5149453E000000;
            8'h7F:   return 64'hAA55AA55AA55AA55;
            default: return (a < 8'h20) ? 64'h0 : ({8{a}} ^ 64'h0102040810204080);
        endcase
    endfunction

    assign rom_data = rom_glyph(rom_addr);

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       ll;
    } exp_t;

    typedef struct {
        logic [7:0]  c;
        logic        inv;
        logic [7:0]  addr;
        logic [63:0] cols;
        int          mode;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_pos = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   last_hs_cyc = 0;
    int   pop_cnt = 0;
    int   ll_cnt = 0;
    int   rdy_mode = 0;
    logic       stall = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Backpressure pattern: 0 = always ready, 1 = toggle every cycle.
    always @(posedge clk) begin
        #2;
        col_ready = (rdy_mode == 1) ? ~col_ready : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_glyph(input logic [63:0] g);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.d  = g[63-8*i -: 8];
            e.l  = (i == 7);
            e.ll = (i == 7) && (model_pos == CPL - 1);
            q.push_back(e);
        end
        model_pos = (model_pos == CPL - 1) ? 0 : model_pos + 1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_stable", {col_valid, col_data}, {1'b1, stall_data});
            end
            if (col_valid && col_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_column: got %h expected none", col_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("column", {col_data, col_last, line_last}, {e.d, e.l, e.ll});
                end
                pop_cnt++;
                if (line_last) ll_cnt++;
                last_hs_cyc = cyc;
            end
            stall      = col_valid && !col_ready;
            stall_data = col_data;
        end
    end

    task automatic send_char(input logic [7:0] c, input logic iv, input logic [63:0] g,
                             input logic chk_addr, input logic [7:0] exp_addr, input logic keep);
        int  n = 0;
        bit  got = 0;
        char_in    = c;
        char_inv   = iv;
        char_valid = 1'b1;
        while (!got && n < 400) begin
            @(negedge clk);
            if (char_ready) got = 1;
            else n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no char_ready expected accept of %h", c);
            char_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (!keep) char_valid = 1'b0;
        if (c == 8'h0A) begin
            bit done;
            do begin
                done = (model_pos == CPL - 1);
                push_glyph({64{iv}});
            end while (!done);
        end else begin
            push_glyph(g);
        end
        if (chk_addr) chk("rom_addr", rom_addr, exp_addr);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d columns pending expected 0", q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   bad;
        int   t0;
        int   base;
        int   n;

        vecs[0] = '{c: 8'h42, inv: 1'b1, addr: 8'h42, cols: 64'hBE80B6B6B6B6C9FF, mode: 1};
        vecs[1] = '{c: 8'hC1, inv: 1'b0, addr: 8'h7F, cols: 64'hAA55AA55AA55AA55, mode: 0};
        vecs[2] = '{c: 8'h01, inv: 1'b0, addr: 8'h01, cols: 64'h0000000000000000, mode: 0};
        vecs[3] = '{c: 8'h01, inv: 1'b1, addr: 8'h01, cols: 64'hFFFFFFFFFFFFFFFF, mode: 1};
        vecs[4] = '{c: 8'h80, inv: 1'b0, addr: 8'h7F, cols: 64'hAA55AA55AA55AA55, mode: 0};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_col_valid", col_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_char_ready", char_ready, 1'b1);
        chk("rst_rom_addr", rom_addr, 8'h00);
        chk("rst_col_data", col_data, 8'h00);
        chk("rst_lasts", {col_last, line_last}, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 'A' with latency check
        send_char(8'h41, 1'b0, 64'h407C4A094A7C4000, 1'b1, 8'h41, 1'b0);
        @(negedge clk);
        chk("load_cycle", {busy, col_valid, char_ready}, 3'b100);
        @(negedge clk);
        chk("first_col_valid", col_valid, 1'b1);
        wait_drain(100);

        for (int i = 0; i < 5; i++) begin
            rdy_mode = vecs[i].mode;
            send_char(vecs[i].c, vecs[i].inv, vecs[i].cols, 1'b1, vecs[i].addr, 1'b0);
            wait_drain(200);
            rdy_mode = 0;
        end

        // LF mid-line pads the rest of the line; rom_addr holds
        send_char(8'h0A, 1'b0, 64'h0, 1'b1, 8'h7F, 1'b0);
        wait_drain(400);

        // 14 glyphs then LF: two blank glyphs with char_ready low
        for (int i = 0; i < 14; i++)
            send_char(8'h61 + 8'(i), 1'b0, rom_glyph(8'h61 + 8'(i)), 1'b0, 8'h00, 1'b0);
        send_char(8'h0A, 1'b0, 64'h0, 1'b0, 8'h00, 1'b0);
        bad = 0;
        n = 0;
        while (q.size() > 1 && n < 200) begin
            if (char_ready) bad++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("pad_char_ready_low", bad, 0);
        wait_drain(50);

        // 16 back-to-back glyphs with char_valid held
        ll_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            send_char(8'h30, 1'b0, rom_glyph(8'h30), 1'b0, 8'h00, 1'b1);
            if (i == 0) t0 = acc_cyc;
        end
        char_valid = 1'b0;
        wait_drain(300);
        chk("b2b_cycles", last_hs_cyc - t0, 144);
        chk("b2b_line_last_cnt", ll_cnt, 1);

        // Reset mid-glyph
        send_char(8'h61, 1'b0, rom_glyph(8'h61), 1'b0, 8'h00, 1'b0);
        wait_drain(100);
        base = pop_cnt;
        send_char(8'h43, 1'b0, rom_glyph(8'h43), 1'b1, 8'h43, 1'b0);
        n = 0;
        while (pop_cnt < base + 3 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("three_cols_seen", pop_cnt - base, 3);
        rst_n = 1'b0;
        q.delete();
        model_pos = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", {col_valid, busy, char_ready, col_data}, {3'b001, 8'h00});
        @(posedge clk);
        #1 rst_n = 1'b1;
        // A full blank line proves char_pos returned to 0
        send_char(8'h0A, 1'b1, 64'h0, 1'b0, 8'h00, 1'b0);
        wait_drain(300);
        repeat (4) @(posedge clk);
        chk("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
